// File: rtl/div_param_pkg.sv
// div_param_pkg
// Shared definitions for the sequential divider in the multdiv unit.
//   - 2-bit FSM state encodings (IDLE/BUSY/FIXUP/DONE)
//   - exception-code convention shared with the multiplier
//   - helper that collapses an exception code to the single exception flag
package div_param_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Exception codes as reported by the multdiv unit; the divider only
  // ever raises divide-by-zero or signed overflow.
  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_DIV_ZERO = 2'd1,
    EXC_OVERFLOW = 2'd2
  } exc_code_t;

  function automatic logic exc_flag(input exc_code_t code);
    return code != EXC_NONE;
  endfunction

endpackage

// File: rtl/div_param_if.sv
// div_param_if
// Pipeline-side handshake bundle for the divider.
//   ctrl_DIV / ctrl_signed       : start request and signedness (master -> divider)
//   data_operandA / operandB     : dividend / divisor (master -> divider)
//   data_result / data_remainder : quotient / remainder (divider -> master)
//   data_exception               : divide-by-zero or signed overflow
//   data_resultRDY               : result valid, held until the next accepted start
interface div_param_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY
  );

endinterface

// File: rtl/div_param_negate.sv
// div_param_negate
// Conditional two's-complement block: result = negate ? -value : value.
// Used for operand magnitudes on entry and for sign restoration of the
// quotient and remainder on exit.
//   value  : input operand
//   negate : 1 selects the two's complement
//   result : value or its negation
module div_param_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/div_param.sv
// div_param
// Parametrised restoring divider, one quotient bit per clock.
// Signed (truncating, remainder follows dividend) or unsigned per operation.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : div_param_if.slave handshake (start, operands, results, flags)
// Latency from acceptance to data_resultRDY is WIDTH+1 edges on the normal
// path and 1 edge for divide-by-zero / signed overflow.
module div_param
  import div_param_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  div_param_if.slave   bus
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             neg_q;
  logic             neg_r;
  exc_code_t        exc_code;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign a_neg    = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
  assign b_neg    = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
  assign div_zero = (bus.data_operandB == '0);
  assign overflow = bus.ctrl_signed & (bus.data_operandA == MIN_VAL) &
                    (bus.data_operandB == '1);

  div_param_negate #(.WIDTH(WIDTH)) u_abs_a (
    .value (bus.data_operandA),
    .negate(a_neg),
    .result(abs_a)
  );

  div_param_negate #(.WIDTH(WIDTH)) u_abs_b (
    .value (bus.data_operandB),
    .negate(b_neg),
    .result(abs_b)
  );

  div_param_negate #(.WIDTH(WIDTH)) u_neg_q (
    .value (quo),
    .negate(neg_q),
    .result(q_out)
  );

  div_param_negate #(.WIDTH(WIDTH)) u_neg_r (
    .value (rem),
    .negate(neg_r),
    .result(r_out)
  );

  // One restoring step: shift {R,Q} left and try subtracting |B| at WIDTH+1
  // bits. The stored remainder is always below |B|, so WIDTH bits hold it;
  // only the shifted value and the trial need the extra bit.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, mag_b};

  // Control FSM and datapath. Special cases preload the quotient/remainder
  // registers with their final values and take one FIXUP edge so that every
  // result leaves through the same output path with latency 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ST_IDLE;
      count              <= '0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      exc_code           <= EXC_NONE;
      mag_b              <= '0;
      quo                <= '0;
      rem                <= '0;
      bus.data_result    <= '0;
      bus.data_remainder <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.ctrl_DIV) begin
            bus.data_resultRDY <= 1'b0;
            count              <= '0;
            if (div_zero) begin
              quo      <= '0;
              rem      <= bus.data_operandA;
              neg_q    <= 1'b0;
              neg_r    <= 1'b0;
              exc_code <= EXC_DIV_ZERO;
              state    <= ST_FIXUP;
            end else if (overflow) begin
              quo      <= MIN_VAL;
              rem      <= '0;
              neg_q    <= 1'b0;
              neg_r    <= 1'b0;
              exc_code <= EXC_OVERFLOW;
              state    <= ST_FIXUP;
            end else begin
              quo      <= abs_a;
              mag_b    <= abs_b;
              rem      <= '0;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              exc_code <= EXC_NONE;
              state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          bus.data_result    <= q_out;
          bus.data_remainder <= r_out;
          bus.data_exception <= exc_flag(exc_code);
          bus.data_resultRDY <= 1'b1;
          state              <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_param.md
Name: div_param

Overview:
- Parametrised sequential integer divider; successor to the fixed 32-bit divider used by the multdiv unit.
- Restoring division, one quotient bit per clock.
- Supports signed and unsigned modes, selected per operation.
- Returns quotient and remainder, with exceptions for divide-by-zero and signed overflow.
- Sits beside the multiplier in the multdiv unit and is driven by the pipeline stall/ready handshake.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits (>=4).
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- clock  input  1  sole clock; rising-edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start request, sampled each rising edge.
- ctrl_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with ctrl_DIV.
- data_operandA  input  WIDTH  dividend, sampled on the accepting edge.
- data_operandB  input  WIDTH  divisor, sampled on the accepting edge.
- data_result  output  WIDTH  quotient, registered.
- data_remainder  output  WIDTH  remainder, registered.
- data_exception  output  1  divide-by-zero or signed overflow; valid while data_resultRDY=1.
- data_resultRDY  output  1  result valid, held until the next accepted start.

Behaviour:
- One clock domain; synchronous, active-high reset.
- Reset: state IDLE, counter 0. data_result, data_remainder, data_exception and data_resultRDY are all 0 at the edge where reset=1. Reset overrides everything, including mid-operation and ctrl_DIV in the same cycle.
- States: IDLE, BUSY, FIXUP, DONE.
- Acceptance:
  - ctrl_DIV=1 in IDLE or DONE is accepted at that edge (E0).
  - ctrl_DIV in BUSY or FIXUP is ignored; no queueing.
  - At E0: data_resultRDY <= 0. Latch neg_q = signed & (A[MSB]^B[MSB]) and neg_r = signed & A[MSB]. Latch |A| and |B| (magnitudes only when signed). Clear the partial remainder (WIDTH+1 bits) and counter.
- Special cases decided at E0 (both go straight to DONE at E1, latency 1, no BUSY):
  - B==0: quotient = 0, remainder = A (raw), exception = 1.
  - signed & A==MIN & B==all-ones: quotient = MIN, remainder = 0, exception = 1.
- Normal path at E0: next state BUSY.
- BUSY, each edge:
  - Shift {R,Q} left 1.
  - Trial = R - |B| at WIDTH+1 bits.
  - Trial non-negative: R <= trial and Q[0] <= 1. Otherwise R is kept and Q[0] <= 0.
  - Counter increments. After WIDTH iterations (edge EWIDTH) go to FIXUP.
- FIXUP, one edge:
  - data_result <= neg_q ? -Q : Q.
  - data_remainder <= neg_r ? -R : R.
  - data_exception <= 0; data_resultRDY <= 1; next state DONE.
- Latency: data_resultRDY rises at edge E(WIDTH+1) after acceptance (33 edges for WIDTH=32).
- Semantics: remainder sign follows the dividend (truncating division). Identity A = Q*B + R holds for all non-exception cases.
- DONE: outputs held stable. ctrl_DIV=1 starts a new operation; ctrl_DIV=0 stays in DONE.
- Outputs change only at FIXUP, at special-case completion, at acceptance (resultRDY only) or at reset.

Decomposition:
- Shared package: state encoding constants (IDLE/BUSY/FIXUP/DONE, 2 bits) and the exception-code convention shared with the multiplier.
- Sub-module: the existing complement block, instantiated for operand magnitude and result/remainder negation.
- Iteration datapath stays inline.

Test Plan:
- Unsigned (WIDTH=32): 100/7. Required: data_result=14, remainder=2, exception=0, data_resultRDY rising exactly 33 edges after the ctrl_DIV edge.
- Signed: -100/7 gives q=-14, r=-2. 100/-7 gives q=-14, r=2. Unsigned 0xFFFFFFFF/2 gives q=0x7FFFFFFF, r=1.
- Divide by zero: 5/0 gives exception=1, q=0, r=5, data_resultRDY one edge after acceptance. Signed 0x80000000/0xFFFFFFFF gives exception=1, q=0x80000000, r=0.
- Reset at iteration 10: all outputs 0 and IDLE after that edge. A new 9/3 then completes with q=3, r=0.
- ctrl_DIV pulsed mid-BUSY with other operands: ignored, original result delivered. A back-to-back start in the same edge as DONE is accepted and data_resultRDY drops.
- WIDTH=8 instance, signed -128/3: q=-42, r=-2, latency 9 edges.
